usr_seq_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the 4-bit universal shift register and drives its mode-select, parallel-load and serial-input pins. On a start request it loads a data word into the register, then issues a programmed number of left or right shifts. Each shift fills with a constant bit or rotates the register's own end bit back in. It reports busy and a one-cycle done, so a higher-level lab FSM or test harness can request shift/rotate operations without cycling the register's mode pins itself.

---
 rtl/usr_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_usr_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: sequencing controller for a 4-bit universal shift register.
// Loads a captured word, then issues a programmed number of left/right
// shifts that either fill with a constant bit or rotate the end bit back in.
// s, x, busy and done are registered; lsi/rsi are decoded from the registered
// state, the captured controls and the register's q feedback.
// Optional build macro: USR_SEQ_ABORT_EN adds an abort input that cancels a
// running operation (LOAD or SHIFT) without pulsing done.
module usr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic             rot,
  input  logic             fill_bit,
  input  logic [WIDTH-1:0] q_fb,
`ifdef USR_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [1:0]       s,
  output logic [WIDTH-1:0] x,
  output logic             lsi,
  output logic             rsi,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] cnt_r;
  logic             dir_r;
  logic             rot_r;
  logic             fill_r;

  logic             abort_req;
  logic             q_msb;
  logic             q_lsb;
  logic             serial;

`ifdef USR_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // End bits of the register, taken as whole-vector reductions so every
  // feedback bit is consumed.
  assign q_msb = |(q_fb >> (WIDTH - 1));
  assign q_lsb = |(q_fb & WIDTH'(1));

  // Serial value for the active shift direction; the idle serial input is 0.
  always_comb begin
    serial = fill_r;
    if (rot_r) serial = dir_r ? q_msb : q_lsb;
    lsi = 1'b0;
    rsi = 1'b0;
    if (state == SHIFT) begin
      if (dir_r) lsi = serial;
      else       rsi = serial;
    end
  end

  // Sequencer FSM with registered mode/handshake outputs.
  // NOTE: every state and output register uses <= so all of them update from
  // the same pre-edge values; blocking assignments here would race.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s         <= S_HOLD;
      x         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      cnt_r     <= '0;
      dir_r     <= 1'b0;
      rot_r     <= 1'b0;
      fill_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          s    <= S_HOLD;
          busy <= 1'b0;
          if (start) begin
            x      <= data_in;
            cnt_r  <= count;
            dir_r  <= dir;
            rot_r  <= rot;
            fill_r <= fill_bit;
            s      <= S_LOAD;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          remaining <= cnt_r;
          if (cnt_r == '0) begin
            s     <= S_HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            s     <= dir_r ? S_LEFT : S_RIGHT;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            s     <= S_HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          s     <= S_HOLD;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Abort only matters while the register is being driven.
      if (abort_req && (state == LOAD || state == SHIFT)) begin
        s         <= S_HOLD;
        busy      <= 1'b0;
        done      <= 1'b0;
        remaining <= '0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl: a behavioural 4-bit universal shift register is
// wired to the controller; expected final words and done cycles are queued
// at start and compared when done appears.
module tb_usr_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic             rot;
  logic             fill_bit;
  logic [WIDTH-1:0] q_model;
  logic [1:0]       s;
  logic [WIDTH-1:0] x;
  logic             lsi;
  logic             rsi;
  logic             busy;
  logic             done;
`ifdef USR_SEQ_ABORT_EN
  logic             abort;
`endif

  typedef struct {
    logic [WIDTH-1:0] q;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .dir      (dir),
    .count    (count),
    .rot      (rot),
    .fill_bit (fill_bit),
    .q_fb     (q_model),
`ifdef USR_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .s        (s),
    .x        (x),
    .lsi      (lsi),
    .rsi      (rsi),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Universal shift register model (no reset, like the real part).
  always @(posedge clk) begin
    case (s)
      2'b01:   q_model <= {rsi, q_model[WIDTH-1:1]};
      2'b10:   q_model <= {q_model[WIDTH-2:0], lsi};
      2'b11:   q_model <= x;
      default: q_model <= q_model;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start cycle and queue the expected outcome.
  task automatic start_op(input logic [3:0] d, input logic dr, input logic [2:0] c,
                          input logic r, input logic f, input logic [3:0] exp_q);
    exp_t e;
    data_in  = d;
    dir      = dr;
    count    = c;
    rot      = r;
    fill_bit = f;
    start    = 1'b1;
    tick();
    start = 1'b0;
    e.q   = exp_q;
    e.cyc = cyc + 1 + int'(c);
    sb.push_back(e);
  endtask

  // Wait (bounded) for done, compare against the queue, confirm the pulse ends.
  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_sb_depth"}, sb.size(), 32'd1);
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_q"}, 32'(q_model), 32'(e.q));
      check({tag, "_cyc"}, cyc, e.cyc);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_s_at_done"}, 32'(s), 32'd0);
    end
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [3:0] frozen;
    reset    = 1'b1;
    start    = 1'b0;
    data_in  = '0;
    dir      = 1'b0;
    count    = '0;
    rot      = 1'b0;
    fill_bit = 1'b0;
`ifdef USR_SEQ_ABORT_EN
    abort    = 1'b0;
`endif

    // 1: reset for two cycles, then idle
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_s", 32'(s), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_lsi", 32'(lsi), 32'd0);
    check("rst_rsi", 32'(rsi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // 2: load 1011, two right shifts filling 0, cycle by cycle
    start_op(4'b1011, 1'b0, 3'd2, 1'b0, 1'b0, 4'b0010);
    check("t2_load_s", 32'(s), 32'd3);
    check("t2_load_x", 32'(x), 32'hB);
    check("t2_load_busy", 32'(busy), 32'd1);
    tick();
    check("t2_sh1_s", 32'(s), 32'd1);
    check("t2_sh1_rsi", 32'(rsi), 32'd0);
    check("t2_sh1_q", 32'(q_model), 32'hB);
    tick();
    check("t2_sh2_s", 32'(s), 32'd1);
    check("t2_sh2_q", 32'(q_model), 32'h5);
    check("t2_sh2_busy", 32'(busy), 32'd1);
    wait_done("t2");

    // 3: rotate left 1001 once, then four times (full wrap)
    start_op(4'b1001, 1'b1, 3'd1, 1'b1, 1'b0, 4'b0011);
    tick();
    check("t3_lsi", 32'(lsi), 32'd1);
    check("t3_rsi", 32'(rsi), 32'd0);
    check("t3_s", 32'(s), 32'd2);
    wait_done("t3a");
    start_op(4'b1001, 1'b1, 3'd4, 1'b1, 1'b0, 4'b1001);
    wait_done("t3b");

    // Fill with 1 on a left shift, and rotate right once
    start_op(4'b0000, 1'b1, 3'd3, 1'b0, 1'b1, 4'b0111);
    wait_done("fill1");
    start_op(4'b0001, 1'b0, 3'd1, 1'b1, 1'b0, 4'b1000);
    wait_done("rotr");

    // 4: count=0 -> LOAD then DONE, busy for one cycle
    start_op(4'b0110, 1'b0, 3'd0, 1'b0, 1'b1, 4'b0110);
    check("t4_busy", 32'(busy), 32'd1);
    wait_done("t4");

    // 5a: start/data changes during SHIFT ignored; rotate right 7 of 1011
    start_op(4'b1011, 1'b0, 3'd7, 1'b1, 1'b0, 4'b0111);
    tick();
    tick();
    start    = 1'b1;
    data_in  = 4'b0000;
    dir      = 1'b1;
    rot      = 1'b0;
    fill_bit = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5a");

    // 5b: reset in the second SHIFT cycle; register freezes, no done
    start_op(4'b1100, 1'b1, 3'd5, 1'b0, 1'b1, 4'b0000);
    void'(sb.pop_back());
    tick();
    tick();
    check("t5b_sh2_q", 32'(q_model), 32'h9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5b_s", 32'(s), 32'd0);
    check("t5b_busy", 32'(busy), 32'd0);
    check("t5b_q", 32'(q_model), 32'h3);
    frozen = q_model;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5b_no_done", 32'(done), 32'd0);
    end
    check("t5b_frozen", 32'(q_model), 32'(frozen));

`ifdef USR_SEQ_ABORT_EN
    // 6: abort sampled at the end of the second shift cycle -> two shifts
    start_op(4'b1000, 1'b0, 3'd5, 1'b0, 1'b0, 4'b0000);
    void'(sb.pop_back());
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_s", 32'(s), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_q", 32'(q_model), 32'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_done", 32'(done), 32'd0);
    end
    check("t6_frozen", 32'(q_model), 32'h2);
    // abort in IDLE has no effect on a following operation
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start_op(4'b0101, 1'b1, 3'd1, 1'b0, 1'b0, 4'b1010);
    wait_done("t6_after");
`endif

    // Back-to-back operation after the last one still works
    start_op(4'b0011, 1'b1, 3'd2, 1'b1, 1'b0, 4'b1100);
    wait_done("b2b");

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
